num_entry: RTL and testbench
============================

# num_entry

Digit-serial number entry block: the inverse direction of the number-system display path. Each press of an active-low push-button latches one digit and a base select from the 8 board switches and accumulates the digit into a binary register (value = value·base + digit). Sits between the board switches/KEY1 button and any consumer of a binary operand, such as the display converter.

## Interface
- VAL_W, 16: width of the accumulated binary value.
- DB_CYCLES, 50000: lockout length in clk cycles after an accepted press. Used only with NUM_ENTRY_DEBOUNCE_EN.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- key_n  in  1  asynchronous active-low enter button (KEY1).
- switches  in  8  [3:0] digit; [5:4] base (00=2, 01=8, 10=10, 11=16); [6] reserved/ignored; [7] clear.
- value  out  VAL_W  accumulated binary value.
- digit_cnt  out  4  number of digits accepted since clear; saturates at 15.
- done  out  1  one-cycle pulse when a press has been processed (accepted, rejected or clear).
- err  out  1  last digit was invalid for its base.
- ovf  out  1  sticky overflow flag.
- busy  out  1  high while FSM is not in IDLE.

## Operation
- Input path:
  - key_n passes through a 3-flop synchronizer s1→s2→s3. All three flops reset to 0, so a key held low through reset release yields no strobe.
  - strobe = s3 & ~s2 (falling edge).
- FSM states: IDLE, LATCH, UPDATE.
  - IDLE→LATCH on strobe. On this edge, switches are captured into dig, base and clr registers.
  - LATCH→UPDATE unconditionally. This cycle computes ext = value·base + dig in VAL_W+4 bits.
  - UPDATE→IDLE unconditionally. Outputs are written and done is asserted.
- Strobes arriving in LATCH or UPDATE are dropped; they are not queued.
- Write rules in UPDATE, in priority order:
  - clr=1: value=0, digit_cnt=0, err=0, ovf=0. Base and digit are ignored.
  - dig ≥ base: err=1. value, digit_cnt and ovf are unchanged.
  - ext[VAL_W+3:VAL_W] ≠ 0: ovf=1, err=0. value and digit_cnt are unchanged (the digit is rejected).
  - Otherwise: value=ext[VAL_W-1:0], err=0, digit_cnt=min(digit_cnt+1,15).
- Multiplication by base uses shifts only: ×2 → <<1, ×8 → <<3, ×16 → <<4, ×10 → (<<3)+(<<1).
- Base may change between digits. Each digit uses the base latched with it.
- ovf clears only on clr or rst.

## Timing
- Reset values: value=0, digit_cnt=0, done=0, err=0, ovf=0, busy=0, FSM=IDLE, lockout counter=0.
- Latency, with edge 1 = first rising edge sampling key_n low:
  - strobe is high after edge 2.
  - LATCH is entered at edge 3.
  - Outputs update at edge 4, and done is high for the cycle after edge 4.
- busy is high for exactly 2 cycles per processed press.
- Minimum spacing between accepted presses is 3 cycles without debounce.
- rst has priority in every state. Asserting rst in LATCH or UPDATE discards the press, produces no done, and sets all outputs to reset values on the next edge.

## Configuration
- NUM_ENTRY_DEBOUNCE_EN defined:
  - A lockout counter loads DB_CYCLES on IDLE→LATCH and decrements to 0.
  - Strobes while the counter is nonzero are ignored, even in IDLE.
  - The counter resets to 0.
- Not defined:
  - No counter is built.
  - Every strobe seen in IDLE is accepted.
  - DB_CYCLES is unused.

## Test plan
All cases use VAL_W=16.
1. Clear after reset: switches=8'h80, press → done pulse at edge 4; value=0, digit_cnt=0, err=0, ovf=0.
2. Decimal entry: clear, then press with switches=8'h22, 8'h25, 8'h25 → value=16'd255, digit_cnt=3, err=0.
3. Hex overflow: clear, then four presses with 8'h3F → value=16'hFFFF, digit_cnt=4. Then press 8'h31 → ovf=1, value=16'hFFFF, digit_cnt=4. Then clear → ovf=0.
4. Invalid digit: clear, press 8'h13 (octal 3) → value=3. Press 8'h18 (octal 8) → err=1, value=3. Press 8'h17 → err=0, value=31.
5. Dropped strobe and debounce:
   - Two falling edges of key_n 2 cycles apart → exactly one done.
   - With NUM_ENTRY_DEBOUNCE_EN and DB_CYCLES=20, a second press 10 cycles later → no done.
   - A press 30 cycles later → done.
6. Reset mid-operation: assert rst for 1 cycle while busy=1 in UPDATE → no done, value=0, digit_cnt=0. Holding key_n low through rst release produces no strobe.

Source files
------------

// File: rtl/num_entry.sv
// num_entry: digit-serial number entry.
// Each press of the active-low enter button latches a digit, a base and a
// clear flag from the board switches and folds the digit into a binary
// accumulator (value = value*base + digit).
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   key_n      asynchronous active-low enter button
//   switches   [3:0] digit, [5:4] base (00=2 01=8 10=10 11=16),
//              [6] ignored, [7] clear
//   value      accumulated binary value (VAL_W bits)
//   digit_cnt  digits accepted since clear, saturating at 15
//   done       one-cycle pulse when a press has been processed
//   err        last digit was invalid for its base
//   ovf        sticky overflow flag (cleared by clear or rst)
//   busy       high while the FSM is not idle
//
// Build option: define NUM_ENTRY_DEBOUNCE_EN to add a lockout counter of
// DB_CYCLES clocks after every accepted press.
module num_entry #(
  parameter int VAL_W     = 16,
  parameter int DB_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_n,
  input  logic [7:0]       switches,
  output logic [VAL_W-1:0] value,
  output logic [3:0]       digit_cnt,
  output logic             done,
  output logic             err,
  output logic             ovf,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, LATCH, UPDATE} state_t;

  state_t           state, state_nxt;
  logic             s1, s2, s3;
  logic             strobe;
  logic             accept;
  logic [3:0]       dig_p0;
  logic [1:0]       base_p0;
  logic             clr_p0;
  logic [VAL_W+3:0] ext_p1;
  logic             dig_bad_p1;
  logic             unused_sw6;

  assign unused_sw6 = switches[6];

  // Shift-and-add multiply by the selected base; width VAL_W+4 holds
  // the worst case (all-ones * 16 + 15) exactly.
  function automatic logic [VAL_W+3:0] mul_base(input logic [VAL_W-1:0] v,
                                                input logic [1:0] b);
    logic [VAL_W+3:0] x;
    x = {4'b0000, v};
    case (b)
      2'b00:   return x << 1;
      2'b01:   return x << 3;
      2'b10:   return (x << 3) + (x << 1);
      default: return x << 4;
    endcase
  endfunction

  function automatic logic [4:0] base_val(input logic [1:0] b);
    case (b)
      2'b00:   return 5'd2;
      2'b01:   return 5'd8;
      2'b10:   return 5'd10;
      default: return 5'd16;
    endcase
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    return (c == 4'd15) ? 4'd15 : c + 4'd1;
  endfunction

  // Reset to 0 so a key already held low when reset releases never looks
  // like a fresh falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= key_n;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign strobe = s3 & ~s2;

`ifdef NUM_ENTRY_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  logic [CNT_W-1:0] lock_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      lock_cnt <= '0;
    else if (state == IDLE && accept)
      lock_cnt <= CNT_W'(DB_CYCLES);
    else if (lock_cnt != '0)
      lock_cnt <= lock_cnt - 1'b1;
  end

  assign accept = strobe && (lock_cnt == '0);
`else
  logic [31:0] unused_db;
  assign unused_db = DB_CYCLES;
  assign accept    = strobe;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state; strobes outside IDLE are simply dropped
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = LATCH;
      LATCH:   state_nxt = UPDATE;
      UPDATE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs; done is masked by rst so a press reset in UPDATE never reports
  always_comb begin
    busy = (state != IDLE);
    done = (state == UPDATE) && !rst;
  end

  // Stage p0: capture switches on the accepted press
  always_ff @(posedge clk) begin
    if (state == IDLE && accept) begin
      dig_p0  <= switches[3:0];
      base_p0 <= switches[5:4];
      clr_p0  <= switches[7];
    end
  end

  // Stage p1: candidate value computed during LATCH
  always_comb begin
    ext_p1     = mul_base(value, base_p0) + {{VAL_W{1'b0}}, dig_p0};
    dig_bad_p1 = ({1'b0, dig_p0} >= base_val(base_p0));
  end

  // Stage p2: results committed on the LATCH->UPDATE edge
  always_ff @(posedge clk) begin
    if (rst) begin
      value     <= '0;
      digit_cnt <= 4'd0;
      err       <= 1'b0;
      ovf       <= 1'b0;
    end else if (state == LATCH) begin
      if (clr_p0) begin
        value     <= '0;
        digit_cnt <= 4'd0;
        err       <= 1'b0;
        ovf       <= 1'b0;
      end else if (dig_bad_p1) begin
        err <= 1'b1;
      end else if (ext_p1[VAL_W+3:VAL_W] != 4'd0) begin
        ovf <= 1'b1;
        err <= 1'b0;
      end else begin
        value     <= ext_p1[VAL_W-1:0];
        err       <= 1'b0;
        digit_cnt <= sat_inc(digit_cnt);
      end
    end
  end

endmodule

// File: tb/tb_num_entry.sv
module tb_num_entry;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_n;
  logic [7:0]  switches;
  logic [15:0] value;
  logic [3:0]  digit_cnt;
  logic        done, err, ovf, busy;

  int checks   = 0;
  int failures = 0;
  int nd, fd, nb;

  always #5 clk = ~clk;

  num_entry #(.VAL_W(16), .DB_CYCLES(20)) dut (
    .clk(clk), .rst(rst), .key_n(key_n), .switches(switches),
    .value(value), .digit_cnt(digit_cnt), .done(done), .err(err),
    .ovf(ovf), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One press: key low for 4 edges, 10 edges observed. Reports done count,
  // index of the first edge after which done was seen, and busy cycles.
  task automatic press(input logic [7:0] sw, output int ndone, output int first,
                       output int nbusy);
    switches = sw;
    key_n    = 1'b0;
    ndone = 0; first = -1; nbusy = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 4) key_n = 1'b1;
      if (done) begin
        ndone++;
        if (first < 0) first = k;
      end
      if (busy) nbusy++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; key_n = 1'b1; switches = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_value", value, 0);
    chk("rst_cnt", digit_cnt, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_busy", busy, 0);
    idle(4);

    // 1: clear, with latency and busy length
    press(8'h80, nd, fd, nb);
    chk("t1_ndone", nd, 1);
    chk("t1_latency", fd, 4);
    chk("t1_busy_cycles", nb, 2);
    chk("t1_value", value, 0);
    chk("t1_cnt", digit_cnt, 0);
    chk("t1_err", err, 0);
    chk("t1_ovf", ovf, 0);

    // 2: decimal 255
    press(8'h80, nd, fd, nb);
    press(8'h22, nd, fd, nb);
    chk("t2_v2", value, 2);
    press(8'h25, nd, fd, nb);
    chk("t2_v25", value, 25);
    press(8'h25, nd, fd, nb);
    chk("t2_value", value, 255);
    chk("t2_cnt", digit_cnt, 3);
    chk("t2_err", err, 0);

    // 3: hex overflow
    press(8'h80, nd, fd, nb);
    for (int i = 0; i < 4; i++) press(8'h3F, nd, fd, nb);
    chk("t3_value", value, 16'hFFFF);
    chk("t3_cnt", digit_cnt, 4);
    chk("t3_ovf0", ovf, 0);
    press(8'h31, nd, fd, nb);
    chk("t3_ovf_done", nd, 1);
    chk("t3_ovf", ovf, 1);
    chk("t3_ovf_err", err, 0);
    chk("t3_ovf_value", value, 16'hFFFF);
    chk("t3_ovf_cnt", digit_cnt, 4);
    press(8'h80, nd, fd, nb);
    chk("t3_clr_ovf", ovf, 0);
    chk("t3_clr_value", value, 0);

    // 4: invalid octal digit
    press(8'h13, nd, fd, nb);
    chk("t4_v3", value, 3);
    press(8'h18, nd, fd, nb);
    chk("t4_bad_done", nd, 1);
    chk("t4_err", err, 1);
    chk("t4_err_value", value, 3);
    chk("t4_err_cnt", digit_cnt, 1);
    press(8'h17, nd, fd, nb);
    chk("t4_err_clr", err, 0);
    chk("t4_value", value, 31);
    chk("t4_cnt", digit_cnt, 2);

    // 5a: two falling edges two cycles apart -> one done
    press(8'h80, nd, fd, nb);
    switches = 8'h21;
    key_n = 1'b0; @(posedge clk); @(negedge clk);
    key_n = 1'b1; @(posedge clk); @(negedge clk);
    key_n = 1'b0; @(posedge clk); @(negedge clk);
    key_n = 1'b1;
    nd = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); @(negedge clk);
      if (done) nd++;
    end
    chk("t5_double_ndone", nd, 1);
    chk("t5_double_value", value, 1);
    chk("t5_double_cnt", digit_cnt, 1);

`ifdef NUM_ENTRY_DEBOUNCE_EN
    // 5b: lockout after an accepted press
    press(8'h80, nd, fd, nb);
    chk("t5_db_first", nd, 1);
    press(8'h21, nd, fd, nb);
    chk("t5_db_locked", nd, 0);
    chk("t5_db_locked_value", value, 0);
    idle(10);
    press(8'h21, nd, fd, nb);
    chk("t5_db_after", nd, 1);
    chk("t5_db_after_value", value, 1);
    idle(25);
`endif

    // 6: reset while in UPDATE, key held low through reset release
    press(8'h80, nd, fd, nb);
    idle(25);
    switches = 8'h25;
    key_n = 1'b0;
    repeat (4) begin @(posedge clk); @(negedge clk); end
    chk("t6_busy_update", busy, 1);
    chk("t6_value_upd", value, 5);
    rst = 1'b1;
    #1;
    chk("t6_done_masked", done, 0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk("t6_value", value, 0);
    chk("t6_cnt", digit_cnt, 0);
    chk("t6_busy", busy, 0);
    nd = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); @(negedge clk);
      if (done) nd++;
    end
    key_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); @(negedge clk);
      if (done) nd++;
    end
    chk("t6_no_strobe", nd, 0);
    idle(25);
    press(8'h25, nd, fd, nb);
    chk("t6_recover_done", nd, 1);
    chk("t6_recover_value", value, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
